// File: rtl/display_page_scheduler.sv
// Shares the seven-segment display and activity LEDs between NUM_PAGES 32-bit status sources.
// A debounced key steps through pages on a short press and toggles a display freeze on a long one.
module display_page_scheduler #(
  parameter int unsigned NUM_PAGES         = 4,
  parameter int unsigned REFRESH_DIV       = 5_000_000,
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_n,
  input  logic [32*NUM_PAGES-1:0]      page_vals,
  input  logic [NUM_PAGES-1:0]         page_valid,
  output logic [31:0]                  disp_value,
  output logic [$clog2(NUM_PAGES)-1:0] page_idx,
  output logic                         frozen,
  output logic                         refresh_tick,
  output logic [NUM_PAGES-1:0]         act_led
);

  localparam int unsigned PageW  = $clog2(NUM_PAGES);
  localparam int unsigned CntMax = (LONG_PRESS_CYCLES > DEBOUNCE_CYCLES) ?
                                   LONG_PRESS_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned RefW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CntW-1:0]  DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0]  LongLast = CntW'(LONG_PRESS_CYCLES - 1);
  localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_DIV - 1);
  localparam logic [PageW-1:0] PageLast = PageW'(NUM_PAGES - 1);

  typedef enum logic [2:0] {
    StUp,
    StDownWait,
    StDown,
    StLong,
    StUpWait
  } key_state_e;

  logic             r_key_meta;
  logic             r_key_s;
  logic [1:0]       r_settle;
  logic             r_armed;
  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic             w_short;
  logic             w_long;
  logic             w_rearm;
  logic             w_advance;
  logic             w_toggle;
  logic             w_arm_set;

  logic [RefW-1:0]      r_rcnt;
  logic                 r_tick;
  logic                 r_adv;
  logic [PageW-1:0]     r_page;
  logic                 r_frozen;
  logic [31:0]          r_disp;
  logic [NUM_PAGES-1:0] r_sticky;
  logic [NUM_PAGES-1:0] r_led;
  logic [31:0]          w_pages [NUM_PAGES];

  // Synchroniser idles high so reset looks like a released key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_meta <= 1'b1;
      r_key_s    <= 1'b1;
      r_settle   <= 2'b00;
    end else begin
      r_key_meta <= key_n;
      r_key_s    <= r_key_meta;
      r_settle   <= {r_settle[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StUp;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_rearm     = 1'b0;
    unique case (r_state)
      StUp: begin
        w_cnt_nxt = '0;
        if (!r_key_s) w_state_nxt = StDownWait;
      end
      StDownWait: begin
        if (r_key_s) begin
          w_state_nxt = StUp;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DebLast) begin
          w_state_nxt = StDown;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StDown: begin
        if (r_key_s) begin
          w_state_nxt = StUpWait;
          w_cnt_nxt   = '0;
          w_short     = 1'b1;
        end else if (r_cnt == LongLast) begin
          w_state_nxt = StLong;
          w_cnt_nxt   = '0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StLong: begin
        w_cnt_nxt = '0;
        if (r_key_s) w_state_nxt = StUpWait;
      end
      StUpWait: begin
        if (!r_key_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DebLast) begin
          w_state_nxt = StUp;
          w_cnt_nxt   = '0;
          w_rearm     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StUp;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A key already held when reset releases must finish a full release before it counts;
  // otherwise arm once the synchroniser carries real samples and shows the key up.
  assign w_arm_set = w_rearm | ((r_state == StUp) & r_key_s & r_settle[1]);
  assign w_advance = w_short & r_armed;
  assign w_toggle  = w_long & r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (w_arm_set) begin
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PAGES; i++) begin
      w_pages[i] = page_vals[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_rcnt <= (r_rcnt == RefLast) ? '0 : r_rcnt + 1'b1;
      r_tick <= (r_rcnt == RefLast);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adv    <= 1'b0;
      r_page   <= '0;
      r_frozen <= 1'b0;
    end else begin
      r_adv <= w_advance;
      if (w_advance) begin
        r_page <= (r_page == PageLast) ? '0 : r_page + 1'b1;
      end
      if (w_toggle) begin
        r_frozen <= ~r_frozen;
      end
    end
  end

  // A tick coinciding with an advance loads the old page; r_adv reloads the new one next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
    end else if ((r_tick && !r_frozen) || r_adv) begin
      r_disp <= w_pages[r_page];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_led    <= '0;
    end else if (r_tick) begin
      r_led    <= r_sticky | page_valid;
      r_sticky <= '0;
    end else begin
      r_sticky <= r_sticky | page_valid;
    end
  end

  assign disp_value   = r_disp;
  assign page_idx     = r_page;
  assign frozen       = r_frozen;
  assign refresh_tick = r_tick;
  assign act_led      = r_led;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Scoreboard bench for display_page_scheduler: expected output changes are queued per output
// with their cycle numbers, and a negedge monitor pops one entry per observed change.
module tb_display_page_scheduler;

  localparam int unsigned NP = 4;
  localparam int KTick = 0;
  localparam int KDisp = 1;
  localparam int KPage = 2;
  localparam int KFrz  = 3;
  localparam int KLed  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_n = 1'b1;
  logic [31:0]   pv [NP];
  logic [32*NP-1:0] page_vals;
  logic [NP-1:0] page_valid;
  logic [31:0]   disp_value;
  logic [1:0]    page_idx;
  logic          frozen;
  logic          refresh_tick;
  logic [NP-1:0] act_led;

  int total = 0;
  int bad = 0;
  int cyc;

  typedef struct packed {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t q_tick[$];
  ev_t q_disp[$];
  ev_t q_page[$];
  ev_t q_frz[$];
  ev_t q_led[$];

  display_page_scheduler #(
    .NUM_PAGES        (NP),
    .REFRESH_DIV      (10),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .page_vals   (page_vals),
    .page_valid  (page_valid),
    .disp_value  (disp_value),
    .page_idx    (page_idx),
    .frozen      (frozen),
    .refresh_tick(refresh_tick),
    .act_led     (act_led)
  );

  always #5 clk = ~clk;

  assign page_vals = {pv[3], pv[2], pv[1], pv[0]};

  // Cycle n is the interval after the n-th rising edge following reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push(input int k, input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    case (k)
      KTick:   q_tick.push_back(e);
      KDisp:   q_disp.push_back(e);
      KPage:   q_page.push_back(e);
      KFrz:    q_frz.push_back(e);
      default: q_led.push_back(e);
    endcase
  endtask

  function automatic ev_t take(input int k);
    ev_t e;
    e.cyc = -1;
    e.val = '0;
    case (k)
      KTick:   if (q_tick.size() > 0) e = q_tick.pop_front();
      KDisp:   if (q_disp.size() > 0) e = q_disp.pop_front();
      KPage:   if (q_page.size() > 0) e = q_page.pop_front();
      KFrz:    if (q_frz.size() > 0)  e = q_frz.pop_front();
      default: if (q_led.size() > 0)  e = q_led.pop_front();
    endcase
    return e;
  endfunction

  function automatic string kname(input int k);
    case (k)
      KTick:   return "tick";
      KDisp:   return "disp_value";
      KPage:   return "page_idx";
      KFrz:    return "frozen";
      default: return "act_led";
    endcase
  endfunction

  task automatic observe(input int k, input logic [31:0] act);
    ev_t e;
    e = take(k);
    total++;
    if (e.cyc != cyc || e.val !== act) begin
      bad++;
      $display("FAIL %s: saw %h at cycle %0d, expected %h at cycle %0d (cycle -1 = none)",
               kname(k), act, cyc, e.val, e.cyc);
    end
  endtask

  // Entries whose cycle has already passed without being observed are misses.
  task automatic flush_missed();
    ev_t e;
    for (int k = 0; k < 5; k++) begin
      e = take(k);
      while (e.cyc >= 0) begin
        if (e.cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL %s missed: nothing seen, expected %h at cycle %0d", kname(k), e.val,
                   e.cyc);
        end
        e = take(k);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    logic [31:0]   p_disp;
    logic [1:0]    p_page;
    logic          p_frz;
    logic [NP-1:0] p_led;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_disp = '0;
        p_page = '0;
        p_frz  = 1'b0;
        p_led  = '0;
      end else begin
        if (refresh_tick)        observe(KTick, 32'd1);
        if (disp_value !== p_disp) observe(KDisp, disp_value);
        if (page_idx !== p_page)   observe(KPage, {30'd0, page_idx});
        if (frozen !== p_frz)      observe(KFrz, {31'd0, frozen});
        if (act_led !== p_led)     observe(KLed, {28'd0, act_led});
        p_disp = disp_value;
        p_page = page_idx;
        p_frz  = frozen;
        p_led  = act_led;
      end
    end
  end

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int p, input int h);
    at_cycle(p);
    key_n = 1'b0;
    at_cycle(p + h);
    key_n = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    pv = '{32'hA, 32'hB, 32'hC, 32'hD};
    page_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 10; c <= 450; c += 10) push(KTick, c, 32'd1);
    push(KDisp, 11, 32'hA);
    push(KPage, 50, 32'd1);  push(KDisp, 51, 32'hB);
    push(KPage, 81, 32'd2);  push(KDisp, 81, 32'hB1); push(KDisp, 82, 32'hC);
    push(KPage, 105, 32'd3); push(KDisp, 106, 32'hD);
    push(KPage, 130, 32'd0); push(KDisp, 131, 32'hA);
    push(KPage, 190, 32'd1); push(KDisp, 191, 32'hB);
    push(KFrz, 237, 32'd1);
    push(KPage, 280, 32'd2); push(KDisp, 281, 32'hC);
    push(KFrz, 332, 32'd0);  push(KDisp, 341, 32'h77);
    push(KLed, 361, 32'h4);  push(KLed, 371, 32'h8);  push(KLed, 381, 32'h0);
    push(KFrz, 417, 32'd1);

    // Short presses; the second one lands its advance on the edge that samples a tick.
    press(35, 12);
    at_cycle(66);  key_n = 1'b0;
    at_cycle(72);  pv[1] = 32'hB1;
    at_cycle(78);  key_n = 1'b1;
    at_cycle(83);  pv[1] = 32'hB;
    press(90, 12);
    press(115, 12);

    // Sub-debounce glitches, then one press with a bouncing release.
    for (int i = 0; i < 5; i++) begin
      at_cycle(140 + 6 * i); key_n = 1'b0;
      at_cycle(143 + 6 * i); key_n = 1'b1;
    end
    at_cycle(175); key_n = 1'b0;
    at_cycle(187); key_n = 1'b1;
    at_cycle(189); key_n = 1'b0;
    at_cycle(191); key_n = 1'b1;
    at_cycle(193); key_n = 1'b0;
    at_cycle(195); key_n = 1'b1;

    // Freeze, short press while frozen, unfreeze.
    at_cycle(210); key_n = 1'b0;
    at_cycle(240); pv[1] = 32'h55;
    at_cycle(250); key_n = 1'b1;
    press(265, 12);
    at_cycle(283); pv[2] = 32'h77;
    press(305, 40);

    // Activity strobes: mid-interval, then on a tick cycle.
    at_cycle(353); page_valid = 4'b0100;
    at_cycle(354); page_valid = 4'b0000;
    at_cycle(370); page_valid = 4'b1000;
    at_cycle(371); page_valid = 4'b0000;

    // Freeze again, then reset while the next press sits in DOWN.
    press(390, 40);
    at_cycle(440); key_n = 1'b0;
    at_cycle(452);
    flush_missed();
    #1 rst_n = 1'b0;
    #1;
    chk("reset disp_value", disp_value, 32'h0);
    chk("reset page_idx", {30'd0, page_idx}, 32'h0);
    chk("reset frozen", {31'd0, frozen}, 32'h0);
    chk("reset refresh_tick", {31'd0, refresh_tick}, 32'h0);
    chk("reset act_led", {28'd0, act_led}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Key held across reset: neither the release nor the long hold may produce an event.
    for (int c = 10; c <= 70; c += 10) push(KTick, c, 32'd1);
    push(KDisp, 11, 32'hA);
    push(KPage, 60, 32'd1);
    push(KDisp, 61, 32'h55);
    at_cycle(35); key_n = 1'b1;
    press(45, 12);
    at_cycle(72);
    flush_missed();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_page_scheduler.md
# display_page_scheduler

Controller that shares the four-digit seven-segment display and the green debug LEDs between several 32-bit status sources in the audio/BPM pipeline (BPM estimate, flux value, FFT debug words, and so on). It runs a refresh divider, debounces a push-button, and advances a display page on a short press. A long press toggles a freeze mode that holds the displayed value. It sits between the estimator's debug outputs and the `display` instance, replacing the ad-hoc refresh counter and LED latching in the top level.

## Interface
- `NUM_PAGES`, default 4: number of selectable sources, must be at least 2.
- `REFRESH_DIV`, default 5_000_000: clock cycles per refresh tick.
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a key edge.
- `LONG_PRESS_CYCLES`, default 50_000_000: held cycles after debounce that count as a long press.
- `clk`, in, 1: system clock (CLOCK_50 domain).
- `rst_n`, in, 1: **one clock; reset is asynchronous and active-low.**
- `key_n`, in, 1: raw push-button, active-low, asynchronous to `clk`.
- `page_vals`, in, 32*NUM_PAGES: source words; page i is bits [32i+31:32i].
- `page_valid`, in, NUM_PAGES: per-source single-cycle activity strobes.
- `disp_value`, out, 32: value driven to the display.
- `page_idx`, out, $clog2(NUM_PAGES): currently selected page.
- `frozen`, out, 1: freeze mode is active.
- `refresh_tick`, out, 1: one-cycle pulse at each refresh.
- `act_led`, out, NUM_PAGES: stretched activity indication per source.

## Operation
- **Reset values:** all outputs are 0. The key synchroniser resets to 1. The debounce FSM resets to UP. All counters reset to 0.
- **Key synchroniser:** 2-flop synchroniser on `key_n` produces `key_s`.
- **Debounce/press FSM:** a single counter `cnt` is cleared on every state change.
  - UP: if `key_s`=0, go to DOWN_WAIT.
  - DOWN_WAIT: if `key_s`=1, go to UP. Otherwise, if `cnt`=DEBOUNCE_CYCLES-1, go to DOWN. Otherwise increment `cnt`.
  - DOWN: if `key_s`=1, go to UP_WAIT and emit a short press (page advance). Otherwise, if `cnt`=LONG_PRESS_CYCLES-1, go to LONG and toggle `frozen`. Otherwise increment `cnt`.
  - LONG: if `key_s`=1, go to UP_WAIT. No page advance is emitted.
  - UP_WAIT: if `key_s`=0, clear `cnt` and stay. Otherwise, if `cnt`=DEBOUNCE_CYCLES-1, go to UP. Otherwise increment `cnt`.
  - Glitches shorter than DEBOUNCE_CYCLES never produce an event.
- **Page advance:** `page_idx` increments and wraps from NUM_PAGES-1 to 0.
- **Refresh divider:**
  - `rcnt` counts 0 to REFRESH_DIV-1, then wraps.
  - `refresh_tick` is registered: it is high for the one cycle after `rcnt`=REFRESH_DIV-1.
- **Display load:** `disp_value` is loaded with page `page_idx` of `page_vals` in either of these cases:
  - on an edge where `refresh_tick`=1 and `frozen`=0;
  - on the edge one cycle after a page advance, regardless of `frozen`.
  - Otherwise `disp_value` holds.
- **Activity stretch:** `sticky[i]` is set by `page_valid[i]`. On an edge with `refresh_tick`=1:
  - `act_led[i]` is loaded with `sticky[i]` OR `page_valid[i]`;
  - `sticky[i]` is cleared.
  - A strobe coincident with the tick therefore appears in `act_led` and is not carried into the next interval.
  - `act_led` is unaffected by `frozen`.

## Timing
- **Key path latency:** a `key_n` fall reaches `key_s` after 2 edges.
  - From `key_s` going low, DOWN is reached after DEBOUNCE_CYCLES+1 edges.
  - `page_idx` changes on the edge where UP_WAIT is entered, one edge after `key_s` rises.
  - `disp_value` reflects the new page 1 cycle later.
- **Refresh period:** the first `refresh_tick` is high in cycle REFRESH_DIV after reset release, then exactly every REFRESH_DIV cycles.
- **Refresh load:** `disp_value` and `act_led` change on the edge that samples `refresh_tick` high, i.e. 1 cycle after the tick.
- **Page advance coinciding with a tick:** the refresh load in that cycle uses the old `page_idx`, and the next cycle reloads with the new page.
- **Freeze toggle:** `frozen` toggles exactly once per long press, on entry to LONG. While frozen, short presses still change `page_idx` and load `disp_value` once.
- **Reset mid-operation:** asserting `rst_n` mid-press or mid-count returns everything to the reset values immediately. Releasing reset while the key is held does not produce an event until the key has passed through UP_WAIT to UP, and then been pressed again.

## Test plan
Use parameters REFRESH_DIV=10, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_PAGES=4, with page_vals = {32'hD, 32'hC, 32'hB, 32'hA}.

1. Reset release with no key activity:
   - `refresh_tick` pulses at cycles 10, 20 and 30.
   - `disp_value` = 32'hA from cycle 11.
   - `page_idx` = 0 and `frozen` = 0 throughout.
2. Key held low for 12 cycles, then released:
   - `page_idx` = 1 one edge after `key_s` rises.
   - `disp_value` = 32'hB one cycle later.
   - A second 12-cycle press wraps through pages 2, 3 and 0.
3. Key low pulses of 3 cycles, repeated 5 times, and bounce during release:
   - `page_idx` stays 0.
   - The release bounce does not re-trigger a press.
4. Key held for 40 cycles:
   - `frozen` = 1, and `page_idx` is unchanged.
   - Changing page 0 to 32'h55 leaves `disp_value` at 32'hA across 3 ticks.
   - A short press gives `disp_value` = 32'hB, which then stays constant.
   - A second long press clears `frozen`, and refresh resumes.
5. `page_valid[2]` pulsed at cycle 13 and `page_valid[3]` pulsed exactly on a tick cycle:
   - After the next tick, `act_led` = 4'b0100 for the first case and 4'b1000 for the second.
   - One further tick with no strobes gives `act_led` = 0.
6. `rst_n` asserted while in DOWN with `frozen` = 1:
   - All outputs read 0 in the same cycle.
   - After release with the key still held, no page advance occurs until the key is released and pressed again.
